// File: rtl/score4_pkg.sv
// Shared types for the Score-4 game core: cell contents, scan directions and
// the engine's control states.
package score4_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        TOK_A = 2'b01,
        TOK_B = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        H,
        V,
        D1,
        D2
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        PLACE,
        SCAN,
        DONE
    } state_t;

    function automatic cell_t tokenOf(input logic p);
        return p ? TOK_B : TOK_A;
    endfunction

endpackage

// File: rtl/score4_win_scan.sv
// Sequential line scanner: walks out from the freshly placed token one cell per
// cycle in each direction and reports whether a run of WIN_LEN was found.
module score4_win_scan
    import score4_pkg::*;
#(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4,
    parameter int CW      = 3,
    parameter int RW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [CW-1:0] origin_col_i,
    input  logic [RW-1:0] origin_row_i,
    input  cell_t         colour_i,
    input  cell_t         probe_cell_i,
    output logic [CW-1:0] probe_col_o,
    output logic [RW-1:0] probe_row_o,
    output logic          done_o,
    output logic          win_o
);

    localparam int PW = CW + 2;
    localparam int QW = RW + 2;
    localparam int LW = $clog2(WIN_LEN + 1);
    localparam logic signed [PW-1:0] COLS_S = PW'(COLS);
    localparam logic signed [QW-1:0] ROWS_S = QW'(ROWS);
    localparam logic [LW-1:0]        WIN_W  = LW'(WIN_LEN);

    logic                 active_q;
    dir_t                 dir_q;
    logic                 neg_q;
    logic [LW-1:0]        run_q;
    logic signed [PW-1:0] pc_q;
    logic signed [QW-1:0] pr_q;
    logic                 done_q;
    logic                 win_q;

    logic signed [PW-1:0] dc, nc, orig_c;
    logic signed [QW-1:0] dr, nr, orig_r;
    logic                 inb, match;
    logic [LW-1:0]        run_inc;

    // The cell probed this cycle is one step beyond the last matching cell.
    always_comb begin
        dc = '0;
        dr = '0;
        case (dir_q)
            H:       dc = PW'(1);
            V:       dr = QW'(1);
            D1:      begin dc = PW'(1); dr = QW'(1); end
            default: begin dc = PW'(1); dr = '1; end
        endcase
        if (neg_q) begin
            dc = -dc;
            dr = -dr;
        end
        orig_c      = $signed({2'b00, origin_col_i});
        orig_r      = $signed({2'b00, origin_row_i});
        nc          = pc_q + dc;
        nr          = pr_q + dr;
        inb         = !nc[PW-1] && (nc < COLS_S) && !nr[QW-1] && (nr < ROWS_S);
        match       = inb && (probe_cell_i == colour_i);
        run_inc     = run_q + LW'(1);
        probe_col_o = nc[CW-1:0];
        probe_row_o = nr[RW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q <= 1'b0;
            dir_q    <= H;
            neg_q    <= 1'b0;
            run_q    <= '0;
            pc_q     <= '0;
            pr_q     <= '0;
            done_q   <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                active_q <= 1'b1;
                dir_q    <= H;
                neg_q    <= 1'b0;
                run_q    <= LW'(1);
                pc_q     <= orig_c;
                pr_q     <= orig_r;
                win_q    <= 1'b0;
            end else if (active_q) begin
                if (match) begin
                    run_q <= run_inc;
                    pc_q  <= nc;
                    pr_q  <= nr;
                    if (run_inc >= WIN_W) begin
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                        win_q    <= 1'b1;
                    end
                end else if (!neg_q) begin
                    neg_q <= 1'b1;
                    pc_q  <= orig_c;
                    pr_q  <= orig_r;
                end else if (dir_q == D2) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end else begin
                    dir_q <= dir_t'(dir_q + 2'd1);
                    neg_q <= 1'b0;
                    run_q <= LW'(1);
                    pc_q  <= orig_c;
                    pr_q  <= orig_r;
                end
            end
        end
    end

    assign done_o = done_q;
    assign win_o  = win_q;

endmodule

// File: rtl/score4_engine.sv
// Score-4 game core: button edge detection, cursor/turn handling, board and
// column heights, result flags and the renderer's registered cell read port.
module score4_engine
    import score4_pkg::*;
#(
    parameter int  COLS        = 7,
    parameter int  ROWS        = 6,
    parameter int  WIN_LEN     = 4,
    parameter int  CURSOR_WRAP = 0,
    localparam int CW          = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          left,
    input  logic          right,
    input  logic          put,
    output logic          player,
    output logic          invalid_move,
    output logic          win_a,
    output logic          win_b,
    output logic          full_panel,
    output logic          busy,
    output logic [CW-1:0] cursor,
    input  logic [CW-1:0] rd_col,
    input  logic [RW-1:0] rd_row,
    output logic [1:0]    rd_cell
);

    localparam int HW = $clog2(ROWS + 1);
    localparam int NW = $clog2(ROWS * COLS + 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [CW-1:0] MID_COL  = CW'(COLS / 2);
    localparam logic [HW-1:0] FULL_H   = HW'(ROWS);
    localparam logic [NW-1:0] ALL_TOK  = NW'(ROWS * COLS);
    localparam logic [CW:0]   COLS_X   = (CW + 1)'(COLS);
    localparam logic [RW:0]   ROWS_X   = (RW + 1)'(ROWS);

    state_t        state_q, state_d;
    logic          left_q, right_q, put_q;
    logic [CW-1:0] cursor_q, cursor_d;
    logic          player_q, player_d;
    logic          invalid_q, invalid_d;
    logic          win_a_q, win_a_d, win_b_q, win_b_d, full_q, full_d;
    cell_t         board_q [COLS][ROWS];
    logic [HW-1:0] height_q [COLS];
    logic [NW-1:0] count_q;
    logic [CW-1:0] place_col_q;
    logic [RW-1:0] place_row_q;
    cell_t         rd_cell_q;

    logic          put_ev, right_ev, left_ev, col_full, do_place, scan_start;
    logic          scan_done, scan_win;
    logic [HW-1:0] cur_height;
    logic [CW-1:0] probe_col;
    logic [RW-1:0] probe_row;
    cell_t         probe_cell;

    assign put_ev     = put & ~put_q;
    assign right_ev   = right & ~right_q & ~put_ev;
    assign left_ev    = left & ~left_q & ~put_ev & ~(right & ~right_q);
    assign cur_height = height_q[cursor_q];
    assign col_full   = (cur_height == FULL_H);
    assign probe_cell = board_q[probe_col][probe_row];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (put_ev && !col_full) state_d = PLACE;
            PLACE:   state_d = SCAN;
            SCAN:    if (scan_done) state_d = (scan_win || count_q == ALL_TOK) ? DONE : IDLE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == PLACE) || (state_q == SCAN);
        scan_start = (state_q == PLACE);
        do_place   = (state_q == IDLE) && put_ev && !col_full;
    end

    // Events only count in IDLE; an end-of-scan decision settles turn and flags.
    always_comb begin
        cursor_d  = cursor_q;
        invalid_d = invalid_q;
        player_d  = player_q;
        win_a_d   = win_a_q;
        win_b_d   = win_b_q;
        full_d    = full_q;
        if (state_q == IDLE) begin
            if (put_ev) begin
                invalid_d = col_full;
            end else if (right_ev) begin
                if (cursor_q != LAST_COL) begin
                    cursor_d  = cursor_q + CW'(1);
                    invalid_d = 1'b0;
                end else if (CURSOR_WRAP != 0) begin
                    cursor_d  = '0;
                    invalid_d = 1'b0;
                end else begin
                    invalid_d = 1'b1;
                end
            end else if (left_ev) begin
                if (cursor_q != '0) begin
                    cursor_d  = cursor_q - CW'(1);
                    invalid_d = 1'b0;
                end else if (CURSOR_WRAP != 0) begin
                    cursor_d  = LAST_COL;
                    invalid_d = 1'b0;
                end else begin
                    invalid_d = 1'b1;
                end
            end
        end
        if (state_q == SCAN && scan_done) begin
            if (scan_win) begin
                if (player_q) win_b_d = 1'b1;
                else          win_a_d = 1'b1;
            end else if (count_q == ALL_TOK) begin
                full_d = 1'b1;
            end else begin
                player_d = ~player_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            put_q       <= 1'b0;
            cursor_q    <= MID_COL;
            player_q    <= 1'b0;
            invalid_q   <= 1'b0;
            win_a_q     <= 1'b0;
            win_b_q     <= 1'b0;
            full_q      <= 1'b0;
            count_q     <= '0;
            place_col_q <= '0;
            place_row_q <= '0;
            rd_cell_q   <= EMPTY;
            for (int c = 0; c < COLS; c++) begin
                height_q[c] <= '0;
                for (int r = 0; r < ROWS; r++) board_q[c][r] <= EMPTY;
            end
        end else begin
            left_q    <= left;
            right_q   <= right;
            put_q     <= put;
            cursor_q  <= cursor_d;
            player_q  <= player_d;
            invalid_q <= invalid_d;
            win_a_q   <= win_a_d;
            win_b_q   <= win_b_d;
            full_q    <= full_d;
            if (do_place) begin
                board_q[cursor_q][cur_height[RW-1:0]] <= tokenOf(player_q);
                height_q[cursor_q] <= cur_height + HW'(1);
                count_q            <= count_q + NW'(1);
                place_col_q        <= cursor_q;
                place_row_q        <= cur_height[RW-1:0];
            end
            rd_cell_q <= ({1'b0, rd_col} < COLS_X && {1'b0, rd_row} < ROWS_X)
                         ? board_q[rd_col][rd_row] : EMPTY;
        end
    end

    score4_win_scan #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .WIN_LEN (WIN_LEN),
        .CW      (CW),
        .RW      (RW)
    ) u_scan (
        .clk          (clk),
        .rst          (rst),
        .start_i      (scan_start),
        .origin_col_i (place_col_q),
        .origin_row_i (place_row_q),
        .colour_i     (tokenOf(player_q)),
        .probe_cell_i (probe_cell),
        .probe_col_o  (probe_col),
        .probe_row_o  (probe_row),
        .done_o       (scan_done),
        .win_o        (scan_win)
    );

    assign player       = player_q;
    assign invalid_move = invalid_q;
    assign win_a        = win_a_q;
    assign win_b        = win_b_q;
    assign full_panel   = full_q;
    assign cursor       = cursor_q;
    assign rd_cell      = rd_cell_q;

endmodule

// File: doc/score4_engine.md
# score4_engine

Parametrised game-logic core for the Score-4 (connect-four) design: holds the board, cursor, turn and result flags, and detects wins of configurable length with a sequential scanner. Sits between the debounced button inputs and the VGA renderer, which reads cells through a registered read port. Generalises the fixed 7×6/4-in-a-row game logic to any board size and win length, and adds an optional cursor wrap mode, a busy flag, and a cell read-back port.

## Interface
- `COLS`, default 7: board columns, 2..16.
- `ROWS`, default 6: board rows, 2..16; row 0 is the bottom row.
- `WIN_LEN`, default 4: tokens in a line needed to win, 2..max(COLS,ROWS).
- `CURSOR_WRAP`, default 0: 1 makes the cursor wrap at the edges; 0 makes an edge move invalid.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset, asynchronous, active-low. One clock; all state resets asynchronously on `rst`=0.
- `left`, `right`, `put` in 1 each: level buttons, synchronous to `clk`; the block acts on the rising edge only.
- `player` out 1: side to move; 0 = A, 1 = B.
- `invalid_move` out 1: last attempted action was rejected.
- `win_a`, `win_b` out 1 each: sticky win flags.
- `full_panel` out 1: sticky flag; board filled with no winner.
- `busy` out 1: a placement or scan is in progress.
- `cursor` out CW: selected column. CW = max(1,$clog2(COLS)).
- `rd_col` in CW, `rd_row` in RW: renderer read address. RW = max(1,$clog2(ROWS)).
- `rd_cell` out 2: cell at (`rd_col`,`rd_row`), cell_t encoding.

## Operation
- Reset values: `cursor`=COLS/2 (3 for the default board), `player`=0, every flag 0, `busy`=0, `rd_cell`=EMPTY, every cell EMPTY, every column height 0, token count 0, FSM in IDLE.
- Edge detect: one register per button. An event is the input high while its register holds 0. In any cycle, `put` has priority over `right`, and `right` over `left`. Lower-priority events in the same cycle are dropped.
- FSM states and transitions:
  - IDLE accepts events; PLACE, SCAN and DONE drop all events without flagging them.
  - IDLE → PLACE on an accepted put.
  - PLACE → SCAN.
  - SCAN → IDLE when there is no win and the board is not full.
  - SCAN → DONE on a win or a full board.
  - DONE holds until reset.
- `right` in IDLE:
  - Cursor below COLS-1: cursor+1.
  - Cursor at COLS-1: wraps to 0 if CURSOR_WRAP=1; otherwise the cursor is unchanged and `invalid_move`=1.
- `left` in IDLE mirrors `right` at column 0 (wraps to COLS-1 when CURSOR_WRAP=1).
- `put` in IDLE:
  - Column height = ROWS: `invalid_move`=1; board, `player` and state unchanged.
  - Otherwise: writes the token of `player` at (cursor, height), increments the height and the token count, and enters PLACE.
- `invalid_move`: cleared by the next accepted left, right or put; it is not self-timed.
- SCAN:
  - Covers four directions in order: horizontal, vertical, diagonal (+1,+1), anti-diagonal (+1,−1).
  - For each direction, walks the positive sense then the negative sense from the placed cell, one cell per cycle.
  - A sense stops at the board edge, at a non-matching cell, or after WIN_LEN-1 steps.
  - `run` starts at 1 for each direction and counts matching cells.
  - Win when `run` ≥ WIN_LEN; remaining directions are skipped.
- End of SCAN:
  - Win: sets `win_a` or `win_b` for the player who placed; `player` does not toggle; state → DONE.
  - No win, token count = ROWS·COLS: `full_panel`=1; state → DONE.
  - Otherwise: `player` toggles; state → IDLE.
  - A win on the last token reports only the win; `full_panel` stays 0.
- Read port: registered, not gated by state. An address outside the board (col ≥ COLS or row ≥ ROWS) returns EMPTY.

## Timing
- Event detected in cycle E; the cursor or `invalid_move` updates at the clk edge ending E.
- Accepted put: cell and height visible at E+1; `busy` high from E+1 until the end of SCAN.
- SCAN is at most 8·(WIN_LEN-1) step cycles plus 1. For WIN_LEN=4, `busy` falls and the flags/`player` update within 26 cycles of E.
- `rd_cell` has one-cycle latency. A write in cycle N is visible on a read issued in N+1.
- `rst` asserted mid-SCAN aborts the scan; all state returns to its reset values immediately.

## Structure
- Package `score4_pkg`:
  - `cell_t` 2-bit enum: EMPTY=00, TOK_A=01, TOK_B=10.
  - `dir_t` enum: H, V, D1, D2.
  - FSM state enum.
- Sub-module `score4_win_scan`:
  - Inputs: start, origin, colour, WIN_LEN.
  - Issues cell addresses to the engine's board read mux.
  - Returns done/win.
  - The engine holds board storage, heights, cursor, flags and the read port.

## Test plan
1. Reset, defaults → `cursor`=3, `player`=0, all flags 0, `rd_cell`=EMPTY for all 42 cells and for address (7,0).
2. 7 puts in column 3 → after 6 puts `player`=0 and column 3 alternates A/B from row 0. The 7th put gives `invalid_move`=1 with `player` unchanged. A following `right` gives `cursor`=4 and `invalid_move`=0.
3. CURSOR_WRAP=0: 4× `left` from reset → cursor 0, and the 4th gives `invalid_move`=1. CURSOR_WRAP=1: `left` at 0 → cursor 6, `invalid_move`=0.
4. Puts in columns 3,3,4,4,5,5,6 → `win_a`=1 with `busy` low within 26 cycles and `player`=0. Later puts change nothing.
5. COLS=5, ROWS=4, WIN_LEN=3: B completes the anti-diagonal (2,0),(1,1),(0,2) → `win_b`=1, `win_a`=0.
6. Fill 7×6 with a no-win pattern → `full_panel`=1 on token 42. Then reset asserted during a SCAN → all outputs return to their reset values immediately.
